// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the two-source round-robin arbiter.
// Contents: grant state enum, select encodings, count-width helper.
package mux_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT1 = 2'd1,
        GNT2 = 2'd2
    } arb_state_t;

    localparam logic SEL_X1 = 1'b0;
    localparam logic SEL_X2 = 1'b1;

    // Bits needed to count 0..hold_max inclusive.
    function automatic int cnt_width(input int hold_max);
        return $clog2(hold_max + 1);
    endfunction

endpackage

// File: rtl/mux_arb_out_reg.sv
// Output register stage of the merged stream: data, valid, optional last.
// Ports: clk, rst_n, load_en, load, d, [last_d] -> f_valid, f_data, [f_last].
// Build option: MUX_ARB_LAST_EN adds the last bit alongside the data.
module mux_arb_out_reg #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_en,
    input  logic              load,
    input  logic [DATA_W-1:0] d,
`ifdef MUX_ARB_LAST_EN
    input  logic              last_d,
    output logic              f_last,
`endif
    output logic              f_valid,
    output logic [DATA_W-1:0] f_data
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_valid <= 1'b0;
            f_data  <= '0;
`ifdef MUX_ARB_LAST_EN
            f_last  <= 1'b0;
`endif
        end else if (load_en) begin
            // A free slot with no incoming beat empties the register.
            f_valid <= load;
            if (load) begin
                f_data <= d;
`ifdef MUX_ARB_LAST_EN
                f_last <= last_d;
`endif
            end
        end
    end

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter merging two valid/ready streams, with a per-grant
// beat limit (HOLD_MAX); drives the select and a registered output stream.
// Ports: in_clk, in_rst_n, source x1/x2 valid/data/ready, merged
// out_f_valid/out_f_data with in_f_ready, and select out_s.
// Build option: MUX_ARB_LAST_EN switches grants on packet boundaries
// (in_x1_last/in_x2_last/out_f_last) instead of on the beat limit.
module mux2_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int HOLD_MAX = 4
) (
    input  logic              in_clk,
    input  logic              in_rst_n,
    input  logic              in_x1_valid,
    input  logic [DATA_W-1:0] in_x1_data,
    output logic              out_x1_ready,
    input  logic              in_x2_valid,
    input  logic [DATA_W-1:0] in_x2_data,
    output logic              out_x2_ready,
`ifdef MUX_ARB_LAST_EN
    input  logic              in_x1_last,
    input  logic              in_x2_last,
    output logic              out_f_last,
`endif
    output logic              out_f_valid,
    output logic [DATA_W-1:0] out_f_data,
    input  logic              in_f_ready,
    output logic              out_s
);

    arb_state_t state, state_nxt;
    // ptr = SEL_X1 favours source 1 when both request from IDLE.
    logic       ptr, ptr_nxt;
    logic       load_en;
    logic       xfer1, xfer2;
    logic       own_valid, oth_valid;
    arb_state_t oth_state;

`ifdef MUX_ARB_LAST_EN
    logic in_pkt, in_pkt_nxt;
    logic own_last;
`else
    localparam int CW = cnt_width(HOLD_MAX);
    localparam logic [CW-1:0] HOLD_C = CW'(HOLD_MAX);
    logic [CW-1:0] cnt, cnt_nxt, cnt_inc;
`endif

    assign load_en      = ~out_f_valid | in_f_ready;
    assign out_x1_ready = (state == GNT1) & load_en;
    assign out_x2_ready = (state == GNT2) & load_en;
    assign xfer1        = in_x1_valid & out_x1_ready;
    assign xfer2        = in_x2_valid & out_x2_ready;
    assign out_s        = (state == GNT2) ? SEL_X2 : SEL_X1;

    // Granted/other views, meaningful only in GNT1/GNT2.
    assign own_valid = (state == GNT2) ? in_x2_valid : in_x1_valid;
    assign oth_valid = (state == GNT2) ? in_x1_valid : in_x2_valid;
    assign oth_state = (state == GNT2) ? GNT1 : GNT2;

`ifdef MUX_ARB_LAST_EN
    assign own_last = (state == GNT2) ? in_x2_last : in_x1_last;
`else
    assign cnt_inc = cnt + CW'(1);
`endif

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
`ifdef MUX_ARB_LAST_EN
        in_pkt_nxt = in_pkt;
`else
        cnt_nxt    = cnt;
`endif
        unique case (state)
            IDLE: begin
`ifndef MUX_ARB_LAST_EN
                cnt_nxt = '0;
`endif
                if (in_x1_valid && (!in_x2_valid || ptr == SEL_X1))
                    state_nxt = GNT1;
                else if (in_x2_valid)
                    state_nxt = GNT2;
            end
            GNT1, GNT2: begin
`ifdef MUX_ARB_LAST_EN
                if (own_valid) begin
                    if (load_en) begin
                        in_pkt_nxt = ~own_last;
                        if (own_last && oth_valid)
                            state_nxt = oth_state;
                    end
                end else if (!in_pkt) begin
                    // Between packets an idle source gives up the grant.
                    state_nxt = oth_valid ? oth_state : IDLE;
                end
`else
                if (own_valid) begin
                    // Stalled beats neither count nor force a switch.
                    if (load_en) begin
                        if (cnt_inc == HOLD_C) begin
                            cnt_nxt = '0;
                            if (oth_valid)
                                state_nxt = oth_state;
                        end else begin
                            cnt_nxt = cnt_inc;
                        end
                    end
                end else begin
                    cnt_nxt   = '0;
                    state_nxt = oth_valid ? oth_state : IDLE;
                end
`endif
            end
            default: state_nxt = IDLE;
        endcase

        // Leaving a grant hands priority to the other source.
        if (state != IDLE && state_nxt != state)
            ptr_nxt = (state == GNT2) ? SEL_X1 : SEL_X2;
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state <= IDLE;
            ptr   <= SEL_X1;
`ifdef MUX_ARB_LAST_EN
            in_pkt <= 1'b0;
`else
            cnt    <= '0;
`endif
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
`ifdef MUX_ARB_LAST_EN
            in_pkt <= in_pkt_nxt;
`else
            cnt    <= cnt_nxt;
`endif
        end
    end

    mux_arb_out_reg #(
        .DATA_W (DATA_W)
    ) u_out_reg (
        .clk     (in_clk),
        .rst_n   (in_rst_n),
        .load_en (load_en),
        .load    (xfer1 | xfer2),
        .d       (xfer2 ? in_x2_data : in_x1_data),
`ifdef MUX_ARB_LAST_EN
        .last_d  (xfer2 ? in_x2_last : in_x1_last),
        .f_last  (out_f_last),
`endif
        .f_valid (out_f_valid),
        .f_data  (out_f_data)
    );

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Directed testbench for mux2_rr_arbiter (DATA_W=8, HOLD_MAX=4).
// Packet-mode case runs only when MUX_ARB_LAST_EN is defined.
module tb_mux2_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       x1_valid, x2_valid, f_ready;
    logic [7:0] x1_data, x2_data;
    logic       x1_ready, x2_ready, f_valid, sel;
    logic [7:0] f_data;
`ifdef MUX_ARB_LAST_EN
    logic       x1_last, x2_last, f_last;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    mux2_rr_arbiter #(
        .DATA_W   (8),
        .HOLD_MAX (4)
    ) dut (
        .in_clk       (clk),
        .in_rst_n     (rst_n),
        .in_x1_valid  (x1_valid),
        .in_x1_data   (x1_data),
        .out_x1_ready (x1_ready),
        .in_x2_valid  (x2_valid),
        .in_x2_data   (x2_data),
        .out_x2_ready (x2_ready),
`ifdef MUX_ARB_LAST_EN
        .in_x1_last   (x1_last),
        .in_x2_last   (x2_last),
        .out_f_last   (f_last),
`endif
        .out_f_valid  (f_valid),
        .out_f_data   (f_data),
        .in_f_ready   (f_ready),
        .out_s        (sel)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        x1_valid = 1'b0;
        x2_valid = 1'b0;
        x1_data  = 8'h00;
        x2_data  = 8'h00;
        f_ready  = 1'b1;
`ifdef MUX_ARB_LAST_EN
        x1_last  = 1'b0;
        x2_last  = 1'b0;
`endif
    endtask

    task automatic do_reset;
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset state
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        check("rst_valid", f_valid, 0);
        check("rst_data", f_data, 0);
        check("rst_sel", sel, 0);
        check("rst_rdy1", x1_ready, 0);
        check("rst_rdy2", x2_ready, 0);
        rst_n = 1'b1;

        // 1: x1 only, six beats, no switch across the count wrap
        x1_valid = 1'b1;
        x1_data  = 8'h11;
        #1;
        check("t1_idle_rdy", x1_ready, 0);
        tick();
        check("t1_gnt_rdy", x1_ready, 1);
        check("t1_gnt_sel", sel, 0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("t1_valid", f_valid, 1);
            check("t1_data", f_data, 32'h11 + i);
            check("t1_sel", sel, 0);
            check("t1_rdy", x1_ready, 1);
            x1_data = 8'h12 + 8'(i);
        end
        x1_valid = 1'b0;
        tick();
        check("t1_drain", f_valid, 0);

        // 2: both valid, 4-beat alternation, x1 first
        do_reset();
        x1_valid = 1'b1;
        x1_data  = 8'h1A;
        x2_valid = 1'b1;
        x2_data  = 8'h2B;
        for (int j = 0; j < 16; j++) begin
            tick();
            check("t2_sel", sel, (j / 4) % 2);
            if (j > 0)
                check("t2_data", f_data,
                      (((j - 1) / 4) % 2) != 0 ? 32'h2B : 32'h1A);
        end

        // 3: downstream stall holds data, next beat appears once
        do_reset();
        x1_valid = 1'b1;
        x1_data  = 8'h22;
        tick();
        tick();
        check("t3_first", f_data, 32'h22);
        f_ready = 1'b0;
        x1_data = 8'h23;
        #1;
        check("t3_stall_rdy", x1_ready, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t3_hold_data", f_data, 32'h22);
            check("t3_hold_valid", f_valid, 1);
            check("t3_hold_rdy", x1_ready, 0);
        end
        f_ready = 1'b1;
        #1;
        check("t3_resume_rdy", x1_ready, 1);
        tick();
        check("t3_next", f_data, 32'h23);
        check("t3_next_valid", f_valid, 1);
        x1_valid = 1'b0;
        tick();
        check("t3_no_dup", f_valid, 0);

        // 4: x1 drops after 2 beats, x2 takes over with a fresh count
        do_reset();
        x1_valid = 1'b1;
        x1_data  = 8'h31;
        x2_valid = 1'b1;
        x2_data  = 8'h41;
        tick();
        check("t4_sel0", sel, 0);
        tick();
        check("t4_b1", f_data, 32'h31);
        x1_data = 8'h32;
        tick();
        check("t4_b2", f_data, 32'h32);
        x1_valid = 1'b0;
        tick();
        check("t4_sw_sel", sel, 1);
        check("t4_sw_valid", f_valid, 0);
        check("t4_sw_rdy2", x2_ready, 1);
        x1_valid = 1'b1;
        x1_data  = 8'h33;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t4_x2_data", f_data, 32'h41);
            check("t4_x2_sel", sel, (k < 3) ? 1 : 0);
        end

        // 5: asynchronous reset mid-burst
        do_reset();
        x2_valid = 1'b1;
        x2_data  = 8'h5C;
        tick();
        check("t5_pre_sel", sel, 1);
        tick();
        check("t5_pre_valid", f_valid, 1);
        #3;
        rst_n = 1'b0;
        #1;
        check("t5_valid", f_valid, 0);
        check("t5_data", f_data, 0);
        check("t5_sel", sel, 0);
        check("t5_rdy1", x1_ready, 0);
        check("t5_rdy2", x2_ready, 0);
        #2;
        rst_n = 1'b1;
        #1;
        check("t5_idle_sel", sel, 0);
        check("t5_idle_rdy2", x2_ready, 0);
        tick();
        check("t5_gnt_sel", sel, 1);
        check("t5_gnt_valid", f_valid, 0);
        tick();
        check("t5_beat", f_data, 32'h5C);
        check("t5_beat_valid", f_valid, 1);

`ifdef MUX_ARB_LAST_EN
        // 6: 6-beat x1 packet stays contiguous, then x2
        do_reset();
        x2_valid = 1'b1;
        x2_data  = 8'h6D;
        x1_valid = 1'b1;
        tick();
        check("t6_sel0", sel, 0);
        for (int k = 1; k <= 6; k++) begin
            x1_data = 8'h50 + 8'(k);
            x1_last = (k == 6);
            tick();
            check("t6_data", f_data, 32'h50 + k);
            check("t6_last", f_last, (k == 6) ? 1 : 0);
            check("t6_sel", sel, (k == 6) ? 1 : 0);
        end
        x1_valid = 1'b0;
        x1_last  = 1'b0;
        tick();
        check("t6_x2", f_data, 32'h6D);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
